// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and widths for the memory-access stage
package mem_stage_pkg;

   localparam int DATA_W = 32;
   localparam int RIDX_W = 5;

   typedef enum logic [1:0] {
      MEM_NONE = 2'b00,
      MEM_LD   = 2'b01,
      MEM_ST   = 2'b10,
      MEM_RSV  = 2'b11
   } mem_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/mem_stage_fsm.sv
// rtl/mem_stage_fsm.sv - transaction state, request/stall generation and ack handling
module mem_stage_fsm
   import mem_stage_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic mem_ack,
   output logic stall,
   output logic mem_req,
   output logic done
);

   state_e state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         stall   <= 1'b0;
         mem_req <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= WAIT;
                  stall   <= 1'b1;
                  mem_req <= 1'b1;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  stall   <= 1'b0;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               stall   <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // An ack outside WAIT belongs to no request and is dropped here.
   assign done = (state == WAIT) && mem_ack;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: word load/store over req/ack, registered writeback bundle
module mem_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RIDX_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [1:0]        in_mem_op,
   input  logic [DATA_W-1:0] in_result_I,
   input  logic              in_result_P,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [RIDX_W-1:0] in_dst,
   input  logic              in_wb_I,
   input  logic              in_wb_P,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_p,
   output logic [RIDX_W-1:0] out_dst,
   output logic              out_wb_I,
   output logic              out_wb_P,
   output logic              out_fault
);

   import mem_stage_pkg::*;

   logic accept, start, done, misal, is_mem, is_fault;

   logic [DATA_W-1:0] hold_res;
   logic [RIDX_W-1:0] hold_dst;
   logic              hold_p, hold_ld, hold_wbi, hold_wbp;

   assign accept   = in_valid && !stall;
   assign misal    = (in_result_I[1:0] != 2'b00);
   assign is_mem   = (in_mem_op == MEM_LD) || (in_mem_op == MEM_ST);
   assign is_fault = (in_mem_op == MEM_RSV) || (is_mem && misal);
   assign start    = accept && is_mem && !misal;

   mem_stage_fsm u_fsm (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mem_ack (mem_ack),
      .stall   (stall),
      .mem_req (mem_req),
      .done    (done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hold_res  <= '0;
         hold_dst  <= '0;
         hold_p    <= 1'b0;
         hold_ld   <= 1'b0;
         hold_wbi  <= 1'b0;
         hold_wbp  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_p     <= 1'b0;
         out_dst   <= '0;
         out_wb_I  <= 1'b0;
         out_wb_P  <= 1'b0;
         out_fault <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // done and accept are exclusive: accept needs IDLE, done needs WAIT.
         if (done) begin
            out_valid <= 1'b1;
            out_data  <= hold_ld ? mem_rdata : hold_res;
            out_p     <= hold_p;
            out_dst   <= hold_dst;
            out_wb_I  <= hold_ld && hold_wbi;
            out_wb_P  <= hold_ld && hold_wbp;
            out_fault <= 1'b0;
         end else if (start) begin
            mem_we    <= (in_mem_op == MEM_ST);
            mem_addr  <= in_result_I[ADDR_W-1:0];
            mem_wdata <= in_wdata;
            hold_res  <= in_result_I;
            hold_dst  <= in_dst;
            hold_p    <= in_result_P;
            hold_ld   <= (in_mem_op == MEM_LD);
            hold_wbi  <= in_wb_I;
            hold_wbp  <= in_wb_P;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_result_I;
            out_p     <= in_result_P;
            out_dst   <= in_dst;
            out_wb_I  <= in_wb_I && !is_fault;
            out_wb_P  <= in_wb_P && !is_fault;
            out_fault <= is_fault;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized bench for mem_stage against a transaction-level model
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [1:0]        in_mem_op;
   logic [DATA_W-1:0] in_result_I;
   logic              in_result_P;
   logic [DATA_W-1:0] in_wdata;
   logic [RIDX_W-1:0] in_dst;
   logic              in_wb_I, in_wb_P;
   logic              stall, mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_p;
   logic [RIDX_W-1:0] out_dst;
   logic              out_wb_I, out_wb_P, out_fault;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RIDX_W(RIDX_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_op(in_mem_op),
      .in_result_I(in_result_I), .in_result_P(in_result_P), .in_wdata(in_wdata),
      .in_dst(in_dst), .in_wb_I(in_wb_I), .in_wb_P(in_wb_P), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_data(out_data), .out_p(out_p), .out_dst(out_dst), .out_wb_I(out_wb_I),
      .out_wb_P(out_wb_P), .out_fault(out_fault)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: one outstanding memory transaction plus the last writeback bundle.
   logic              m_pend, m_we, m_ld, m_pp, m_pwbi, m_pwbp;
   logic [DATA_W-1:0] m_addr, m_wd, m_res;
   logic [RIDX_W-1:0] m_pdst;
   logic              e_valid, e_p, e_wbi, e_wbp, e_fault;
   logic [DATA_W-1:0] e_data;
   logic [RIDX_W-1:0] e_dst;

   task automatic model_reset();
      m_pend = 0; e_valid = 0; e_data = '0; e_dst = '0;
      e_p = 0; e_wbi = 0; e_wbp = 0; e_fault = 0;
   endtask

   task automatic model_step(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] res,
                             input logic p, input logic [DATA_W-1:0] wd, input logic [RIDX_W-1:0] dst,
                             input logic wbi, input logic wbp, input logic ack, input logic [DATA_W-1:0] rd);
      e_valid = 0;
      if (m_pend) begin
         if (ack) begin
            e_valid = 1; e_data = m_ld ? rd : m_res; e_p = m_pp; e_dst = m_pdst;
            e_wbi = m_ld & m_pwbi; e_wbp = m_ld & m_pwbp; e_fault = 0;
            m_pend = 0;
         end
      end else if (v) begin
         if (op == 2'd0) begin
            e_valid = 1; e_data = res; e_p = p; e_dst = dst; e_wbi = wbi; e_wbp = wbp; e_fault = 0;
         end else if (op == 2'd3 || res % 4 != 0) begin
            e_valid = 1; e_data = res; e_p = p; e_dst = dst; e_wbi = 0; e_wbp = 0; e_fault = 1;
         end else begin
            m_pend = 1; m_we = (op == 2'd2); m_ld = (op == 2'd1); m_addr = res; m_wd = wd;
            m_res = res; m_pp = p; m_pdst = dst; m_pwbi = wbi; m_pwbp = wbp;
         end
      end
   endtask

   task automatic compare();
      check("stall", stall, m_pend);
      check("mem_req", mem_req, m_pend);
      if (m_pend) begin
         check("mem_addr", mem_addr, m_addr);
         check("mem_we", mem_we, m_we);
         check("mem_wdata", mem_wdata, m_wd);
      end
      check("out_valid", out_valid, e_valid);
      check("out_data", out_data, e_data);
      check("out_dst", out_dst, e_dst);
      if (e_valid) begin
         check("out_p", out_p, e_p);
         check("out_wb_I", out_wb_I, e_wbi);
         check("out_wb_P", out_wb_P, e_wbp);
         check("out_fault", out_fault, e_fault);
      end
   endtask

   task automatic cyc(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] res,
                      input logic p, input logic [DATA_W-1:0] wd, input logic [RIDX_W-1:0] dst,
                      input logic wbi, input logic wbp, input logic ack, input logic [DATA_W-1:0] rd);
      in_valid = v; in_mem_op = op; in_result_I = res; in_result_P = p; in_wdata = wd;
      in_dst = dst; in_wb_I = wbi; in_wb_P = wbp; mem_ack = ack; mem_rdata = rd;
      model_step(v, op, res, p, wd, dst, wbi, wbp, ack, rd);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic do_reset();
      rst = 1; in_valid = 0; in_mem_op = 0; in_result_I = 0; in_result_P = 0; in_wdata = 0;
      in_dst = 0; in_wb_I = 0; in_wb_P = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", stall, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_p", out_p, 0);
      check("rst_out_dst", out_dst, 0);
      check("rst_out_wb", {out_wb_I, out_wb_P, out_fault}, 0);
      model_reset();
      rst = 0;
   endtask

   logic              r_v, r_p, r_wbi, r_wbp, r_ack;
   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_res, r_wd;
   logic [RIDX_W-1:0] r_dst;
   int                wait_cnt;

   initial begin
      do_reset();

      // Passthrough, then back-to-back passthroughs.
      cyc(1, MEM_NONE, 32'h0000_00AB, 0, 0, 5'd3, 1, 0, 0, 0);
      check("pass_data", out_data, 32'hAB);
      cyc(1, MEM_NONE, 32'h0000_0011, 1, 0, 5'd4, 0, 1, 1, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Zero-wait load.
      cyc(1, MEM_LD, 32'h100, 0, 0, 5'd7, 1, 0, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      check("ld0_data", out_data, 32'hDEAD_BEEF);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Store with three WAIT cycles.
      cyc(1, MEM_ST, 32'h204, 1, 32'h1234_5678, 5'd9, 1, 1, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 1, 0);
      check("st_wb", {out_valid, out_wb_I, out_wb_P}, 3'b100);

      // Misaligned load and reserved op.
      cyc(1, MEM_LD, 32'h102, 1, 0, 5'd2, 1, 1, 0, 0);
      check("mis_fault", out_fault, 1);
      cyc(1, MEM_RSV, 32'h100, 0, 0, 5'd6, 1, 1, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Back-pressure: second op held during WAIT.
      cyc(1, MEM_LD, 32'h40, 0, 0, 5'd1, 1, 0, 0, 0);
      cyc(1, MEM_NONE, 32'h55, 0, 0, 5'd8, 1, 0, 0, 0);
      cyc(1, MEM_NONE, 32'h55, 0, 0, 5'd8, 1, 0, 1, 32'hCAFE_0001);
      cyc(1, MEM_NONE, 32'h55, 0, 0, 5'd8, 1, 0, 0, 0);
      check("bp_second", {out_valid, out_data}, {1'b1, 32'h55});
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-WAIT.
      cyc(1, MEM_ST, 32'h300, 0, 32'hAAAA_5555, 5'd4, 0, 0, 0, 0);
      rst = 1;
      #1;
      check("rstw_mem_req", mem_req, 0);
      check("rstw_stall", stall, 0);
      check("rstw_out_valid", out_valid, 0);
      do_reset();
      cyc(1, MEM_NONE, 32'h77, 1, 0, 5'd12, 1, 1, 0, 0);
      cyc(0, MEM_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic; upstream holds its instruction while stalled.
      wait_cnt = 0;
      r_v = 0; r_op = 0; r_res = 0; r_p = 0; r_wd = 0; r_dst = 0; r_wbi = 0; r_wbp = 0;
      for (int i = 0; i < 800; i++) begin
         if (!m_pend) begin
            r_v   = ($urandom_range(0, 3) != 0);
            r_op  = 2'($urandom_range(0, 3));
            r_res = $urandom;
            if ($urandom_range(0, 3) != 0) r_res[1:0] = 2'b00;
            r_p   = 1'($urandom_range(0, 1));
            r_wd  = $urandom;
            r_dst = RIDX_W'($urandom_range(0, 31));
            r_wbi = 1'($urandom_range(0, 1));
            r_wbp = 1'($urandom_range(0, 1));
            wait_cnt = 0;
            r_ack = 1'($urandom_range(0, 1));
         end else begin
            r_ack = ($urandom_range(0, 2) == 0) || (wait_cnt >= 4);
            wait_cnt++;
         end
         cyc(r_v, r_op, r_res, r_p, r_wd, r_dst, r_wbi, r_wbp, r_ack, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
